alarm_ctrl_front: RTL and testbench

Front-end control stage for the alarm clock. It generates the 1 Hz time base from the system clock and synchronises and debounces the raw board buttons and switches. It also runs the mode state machine that produces the `ps` mode code and the cleaned set/hh/mm/stop controls consumed by the `clock` datapath block. It sits between the board I/O pins and `clock`.

---
 rtl/alarm_pkg.sv | 31 +++
 rtl/alarm_ctrl_front_debounce.sv | 77 +++++++
 rtl/alarm_ctrl_front.sv | 143 ++++++++++++++
 tb/tb_alarm_ctrl_front.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm clock: mode encodings, default timing
// parameters and the mode-advance helper used by the front-end FSM.
package alarm_pkg;

    // Default system clock frequency; also the prescaler period in cycles.
    localparam int unsigned CLK_HZ_DEFAULT    = 50_000_000;
    // Default number of stable cycles before a debounced input is accepted.
    localparam int unsigned DB_CYCLES_DEFAULT = 1_000_000;

    // Mode codes as seen by the clock datapath on ps.
    typedef enum logic [1:0] {
        MODE_CLOCK     = 2'b00,
        MODE_ALARM     = 2'b01,
        MODE_TIMER     = 2'b10,
        MODE_STOPWATCH = 2'b11
    } mode_t;

    // Mode sequence followed on each accepted mode press.
    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        unique case (cur)
            MODE_CLOCK:     nxt = MODE_ALARM;
            MODE_ALARM:     nxt = MODE_TIMER;
            MODE_TIMER:     nxt = MODE_STOPWATCH;
            MODE_STOPWATCH: nxt = MODE_CLOCK;
            default:        nxt = MODE_CLOCK;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/alarm_ctrl_front_debounce.sv
// Input conditioner for one raw board signal: 2-FF synchroniser, stability
// counter that accepts a new level after DB_CYCLES steady cycles, and a
// rising-edge pulse on the accepted level. The pulse is suppressed until the
// input has been seen released after reset, so a button held through reset
// never looks like a fresh press.
module debounce
    import alarm_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic RST,
    input  logic din,
    input  logic RST_VAL,
    output logic dout,
    output logic rise
);

    localparam int unsigned     CNT_W    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             din_s;
    logic [CNT_W-1:0] cnt;
    logic             acc;
    logic [1:0]       fill;
    logic             armed;

    assign din_s = sync_q[1];
    assign dout  = acc;

    // Two-stage synchroniser bringing the asynchronous pin into the clk domain.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, exactly like the hardware.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            sync_q <= {RST_VAL, RST_VAL};
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    // Arm the edge detector once the synchroniser holds real samples and both
    // the synchronised and accepted levels show the released state.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            fill <= {fill[0], 1'b1};
            if (fill[1] && !acc && !din_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Stability counter, accepted level and one-cycle press pulse.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            cnt  <= '0;
            acc  <= RST_VAL;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (din_s == acc) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt  <= '0;
                acc  <= din_s;
                rise <= din_s & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/alarm_ctrl_front.sv
// Front-end control stage of the alarm clock: 1 Hz time base, conditioning of
// the raw buttons and switches, and the mode state machine driving ps.
module alarm_ctrl_front
    import alarm_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       mode_btn_n,
    input  logic       set_btn_n,
    input  logic       stop_btn_n,
    input  logic       sw_set,
    input  logic       sw_hh,
    input  logic       sw_mm,
    output logic       clk_1s,
    output logic       tick_1s,
    output logic [1:0] ps,
    output logic       set_btn,
    output logic       stop_buzzer,
    output logic       set,
    output logic       set_hh,
    output logic       set_mm
);

    localparam int unsigned      DIV_W    = $clog2(CLK_HZ);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_HZ / 2);

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;

    logic  mode_press;
    logic  stop_press;
    logic  set_btn_lvl;
    mode_t state_q;
    mode_t state_d;

    // Conditioned signals that exist on every debouncer but are not needed here.
    logic unused_mode_lvl;
    logic unused_stop_lvl;
    logic unused_set_btn_rise;
    logic unused_set_rise;
    logic unused_hh_rise;
    logic unused_mm_rise;

    // ------------------------------------------------------------------
    // Input conditioning; buttons are inverted so 1 means pressed inside.
    // ------------------------------------------------------------------
    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_mode (
        .clk(clk), .RST(RST), .din(~mode_btn_n), .RST_VAL(1'b0),
        .dout(unused_mode_lvl), .rise(mode_press)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set_btn (
        .clk(clk), .RST(RST), .din(~set_btn_n), .RST_VAL(1'b0),
        .dout(set_btn_lvl), .rise(unused_set_btn_rise)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
        .clk(clk), .RST(RST), .din(~stop_btn_n), .RST_VAL(1'b0),
        .dout(unused_stop_lvl), .rise(stop_press)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw_set (
        .clk(clk), .RST(RST), .din(sw_set), .RST_VAL(1'b0),
        .dout(set), .rise(unused_set_rise)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw_hh (
        .clk(clk), .RST(RST), .din(sw_hh), .RST_VAL(1'b0),
        .dout(set_hh), .rise(unused_hh_rise)
    );

    debounce #(.DB_CYCLES(DB_CYCLES)) u_db_sw_mm (
        .clk(clk), .RST(RST), .din(sw_mm), .RST_VAL(1'b0),
        .dout(set_mm), .rise(unused_mm_rise)
    );

    // ------------------------------------------------------------------
    // 1 Hz prescaler
    // ------------------------------------------------------------------

    // Next divider value, wrapping after CLK_HZ-1.
    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end

    // Divider counter, registered square wave and one-cycle second tick.
    // NOTE: only control/counter flops carry a reset; the reset value is the
    // documented power-on state of each output.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            div_cnt <= '0;
            clk_1s  <= 1'b0;
            tick_1s <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            clk_1s  <= (div_cnt >= DIV_HALF);
            tick_1s <= (div_nxt == DIV_LAST);
        end
    end

    // ------------------------------------------------------------------
    // Mode state machine
    // ------------------------------------------------------------------

    // Mode state register.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_q <= MODE_CLOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Advance on a mode press unless a set operation is in progress.
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (mode_press && !set) begin
            state_d = next_mode(state_q);
        end
    end

    // Mode code and active-low set-button level.
    always_comb begin
        ps      = state_q;
        set_btn = ~set_btn_lvl;
    end

    // Buzzer-stop pulse, one cycle after the accepted stop press.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stop_buzzer <= 1'b0;
        end else begin
            stop_buzzer <= stop_press;
        end
    end

endmodule

// File: tb/tb_alarm_ctrl_front.sv
// Self-checking bench for alarm_ctrl_front with a short prescaler period and
// debounce window. Expected values come from the behavioural rules of the
// block: a press is accepted iff the raw level is held for at least DB
// cycles and shows up 2+DB cycles later, and the time base is a function of
// the number of clock edges since reset release.
module tb_alarm_ctrl_front;

    localparam int CLK_HZ = 10;
    localparam int DB     = 4;

    logic clk        = 1'b0;
    logic RST        = 1'b1;
    logic mode_btn_n = 1'b1;
    logic set_btn_n  = 1'b1;
    logic stop_btn_n = 1'b1;
    logic sw_set     = 1'b0;
    logic sw_hh      = 1'b0;
    logic sw_mm      = 1'b0;

    logic       clk_1s;
    logic       tick_1s;
    logic [1:0] ps;
    logic       set_btn;
    logic       stop_buzzer;
    logic       set;
    logic       set_hh;
    logic       set_mm;

    int total = 0;
    int bad   = 0;
    int edges_since_rst = 0;
    int exp_ps = 0;          // model: mode index 0..3
    bit exp_set = 1'b0;      // model: settled level of sw_set

    always #5 clk = ~clk;

    alarm_ctrl_front #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB)) dut (
        .clk(clk), .RST(RST),
        .mode_btn_n(mode_btn_n), .set_btn_n(set_btn_n), .stop_btn_n(stop_btn_n),
        .sw_set(sw_set), .sw_hh(sw_hh), .sw_mm(sw_mm),
        .clk_1s(clk_1s), .tick_1s(tick_1s), .ps(ps), .set_btn(set_btn),
        .stop_buzzer(stop_buzzer), .set(set), .set_hh(set_hh), .set_mm(set_mm)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Edges since the last reset release; drives the time-base expectations.
    always @(posedge clk or posedge RST) begin
        if (RST) edges_since_rst <= 0;
        else     edges_since_rst <= edges_since_rst + 1;
    end

    // Time base: tick in every CLK_HZ-th cycle, square wave high for the
    // second half of each second, one cycle behind the count.
    always @(negedge clk) begin
        check("tick_1s", tick_1s, (edges_since_rst % CLK_HZ) == CLK_HZ - 1);
        check("clk_1s", clk_1s,
              edges_since_rst >= 1 && ((edges_since_rst - 1) % CLK_HZ) >= CLK_HZ / 2);
    end

    // Mode press held for 'hold' cycles (hold >= 8); checks the update lands
    // exactly 7 cycles after the falling raw edge, and only once.
    task automatic mode_press(input int hold, input string tag);
        int old_ps;
        int new_ps;
        old_ps = exp_ps;
        new_ps = (hold >= DB && !exp_set) ? (exp_ps + 1) % 4 : exp_ps;
        mode_btn_n = 1'b0;
        step(6);
        check({tag, "_pre"}, ps, old_ps);
        step(1);
        check({tag, "_upd"}, ps, new_ps);
        step(hold - 7);
        mode_btn_n = 1'b1;
        step(12);
        check({tag, "_rel"}, ps, new_ps);
        exp_ps = new_ps;
    endtask

    // Short glitch on the mode button; must leave ps untouched.
    task automatic mode_glitch(input int len, input string tag);
        mode_btn_n = 1'b0;
        step(len);
        mode_btn_n = 1'b1;
        step(12);
        check(tag, ps, exp_ps);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int pulses;
        int first_at;
        int len;
        bit hh;
        bit mm;

        // Reset state.
        step(2);
        check("rst_ps", ps, 0);
        check("rst_stop", stop_buzzer, 0);
        check("rst_set", set, 0);
        check("rst_set_hh", set_hh, 0);
        check("rst_set_mm", set_mm, 0);
        check("rst_set_btn", set_btn, 1);
        RST = 1'b0;

        // Free run over three seconds; time base is checked in the background.
        step(35);
        check("run_ps", ps, 0);

        // Four clean presses walk through all modes and back to CLOCK.
        for (int i = 0; i < 4; i++) mode_press(8, "clean");
        check("wrap_ps", ps, 0);

        // Glitches shorter than the window, including the 3-cycle boundary.
        mode_glitch(3, "glitch3");
        for (int i = 0; i < 3; i++) begin
            len = $urandom_range(1, DB - 1);
            mode_glitch(len, "glitch_rnd");
        end

        // Randomly timed presses, some held for a long time (single advance).
        for (int i = 0; i < 6; i++) mode_press($urandom_range(8, 30), "rnd_press");

        // Set switch blocks mode changes; acceptance lands 2+DB cycles later.
        sw_set = 1'b1;
        step(5);
        check("sw_set_pre", set, 0);
        step(1);
        check("sw_set_acc", set, 1);
        exp_set = 1'b1;
        step(4);
        mode_press(8, "press_in_set");
        sw_set = 1'b0;
        step(10);
        check("sw_set_clr", set, 0);
        exp_set = 1'b0;
        mode_press(8, "press_after_set");

        // Hour/minute switches with random levels.
        for (int i = 0; i < 4; i++) begin
            hh = 1'($urandom_range(0, 1));
            mm = 1'($urandom_range(0, 1));
            sw_hh = hh;
            sw_mm = mm;
            step(10);
            check("sw_hh", set_hh, hh);
            check("sw_mm", set_mm, mm);
        end

        // Set button level, active-low output, exact acceptance cycle.
        set_btn_n = 1'b0;
        step(5);
        check("set_btn_pre", set_btn, 1);
        step(1);
        check("set_btn_acc", set_btn, 0);
        step(10);
        set_btn_n = 1'b1;
        step(5);
        check("set_btn_rel_pre", set_btn, 0);
        step(1);
        check("set_btn_rel", set_btn, 1);

        // Stop button held 50 cycles: one pulse, 7 cycles after the press.
        pulses   = 0;
        first_at = -1;
        stop_btn_n = 1'b0;
        for (int i = 1; i <= 62; i++) begin
            if (i == 51) stop_btn_n = 1'b1;
            step(1);
            if (stop_buzzer === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = i;
            end
        end
        check("stop_pulses", pulses, 1);
        check("stop_latency", first_at, 7);

        // Stop glitch shorter than the window: no pulse.
        pulses = 0;
        stop_btn_n = 1'b0;
        step(DB - 1);
        stop_btn_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (stop_buzzer === 1'b1) pulses++;
        end
        check("stop_glitch", pulses, 0);

        // Reach ALARM, press and hold into TIMER, reset while held.
        for (int i = 0; i < 4 && exp_ps != 1; i++) mode_press(8, "to_alarm");
        check("pre_rst_alarm", ps, 1);
        mode_btn_n = 1'b0;
        step(7);
        check("held_timer", ps, 2);
        step(3);
        RST = 1'b1;
        #1;
        check("async_rst_ps", ps, 0);
        exp_ps = 0;
        step(3);
        RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("held_after_rst", ps, 0);
        end
        mode_btn_n = 1'b1;
        step(12);
        check("released_after_rst", ps, 0);
        mode_press(8, "press_after_rst");
        check("final_ps", ps, 1);

        step(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
